// File: rtl/core_clk_sequencer.sv
// Per-core clock/reset sequencer: it gates the core clock, retunes the PLL feedback
// divider, waits for a stable lock and then releases the clock again.
module core_clk_sequencer #(
  parameter int unsigned FB_DIV_WIDTH  = 12,
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1024
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic [FB_DIV_WIDTH-1:0] fb_div_req_i,
  input  logic                    clk_en_req_i,
  input  logic                    arst_req_i,
  input  logic                    glob_arst_i,
  input  logic                    err_clr_i,
  input  logic                    pll_locked_i,
  output logic [FB_DIV_WIDTH-1:0] pll_fb_div_o,
  output logic [FB_DIV_WIDTH-1:0] fb_div_actual_o,
  output logic                    core_clk_en_o,
  output logic                    core_arst_o,
  output logic                    busy_o,
  output logic                    lock_err_o
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMR_W  = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GATE, RETUNE, LOCK_WAIT} state_t;

  state_t                  state, state_nxt;
  logic [GATE_W-1:0]       gate_cnt, gate_cnt_nxt;
  logic [SET_W-1:0]        lock_cnt, lock_cnt_nxt, lock_inc;
  logic [TMR_W-1:0]        timer, timer_nxt, timer_inc;
  logic [FB_DIV_WIDTH-1:0] pll_div_nxt, actual_nxt;
  logic                    clk_en_nxt, arst_nxt, busy_nxt, err_nxt, err_set;

  // State and output registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state           <= IDLE;
      gate_cnt        <= '0;
      lock_cnt        <= '0;
      timer           <= '0;
      pll_fb_div_o    <= '0;
      fb_div_actual_o <= '0;
      core_clk_en_o   <= 1'b0;
      core_arst_o     <= 1'b1;
      busy_o          <= 1'b0;
      lock_err_o      <= 1'b0;
    end else begin
      state           <= state_nxt;
      gate_cnt        <= gate_cnt_nxt;
      lock_cnt        <= lock_cnt_nxt;
      timer           <= timer_nxt;
      pll_fb_div_o    <= pll_div_nxt;
      fb_div_actual_o <= actual_nxt;
      core_clk_en_o   <= clk_en_nxt;
      core_arst_o     <= arst_nxt;
      busy_o          <= busy_nxt;
      lock_err_o      <= err_nxt;
    end
  end

  // Next-state and next-output logic; the clock stays gated outside IDLE
  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    lock_cnt_nxt = lock_cnt;
    timer_nxt    = timer;
    pll_div_nxt  = pll_fb_div_o;
    actual_nxt   = fb_div_actual_o;
    clk_en_nxt   = 1'b0;
    err_set      = 1'b0;
    lock_inc     = (pll_locked_i && (lock_cnt < SET_W'(SETTLE_CYCLES)))
                   ? lock_cnt + SET_W'(1)
                   : (pll_locked_i ? lock_cnt : '0);
    timer_inc    = (timer < TMR_W'(LOCK_TIMEOUT)) ? timer + TMR_W'(1) : timer;

    case (state)
      IDLE: begin
        if (fb_div_req_i != pll_fb_div_o) begin
          state_nxt    = GATE;
          gate_cnt_nxt = '0;
        end else begin
          clk_en_nxt = clk_en_req_i & pll_locked_i;
        end
      end
      GATE: begin
        if (gate_cnt >= GATE_W'(GATE_CYCLES - 1)) begin
          state_nxt    = RETUNE;
          gate_cnt_nxt = '0;
        end else begin
          gate_cnt_nxt = gate_cnt + GATE_W'(1);
        end
      end
      RETUNE: begin
        pll_div_nxt  = fb_div_req_i;
        lock_cnt_nxt = '0;
        timer_nxt    = '0;
        state_nxt    = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        lock_cnt_nxt = lock_inc;
        timer_nxt    = timer_inc;
        // A settle and a timeout on the same edge resolve as success
        if (lock_inc == SET_W'(SETTLE_CYCLES)) begin
          actual_nxt = pll_fb_div_o;
          state_nxt  = IDLE;
        end else if (timer_inc == TMR_W'(LOCK_TIMEOUT)) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
    arst_nxt = arst_req_i | glob_arst_i;
    err_nxt  = err_set ? 1'b1 : (err_clr_i ? 1'b0 : lock_err_o);
  end

endmodule

// File: tb/tb_core_clk_sequencer.sv
// Randomized scoreboard bench for core_clk_sequencer against a timeline-based reference model.
module tb_core_clk_sequencer;

  localparam int unsigned W       = 12;
  localparam int unsigned GATE    = 4;
  localparam int unsigned SETTLE  = 8;
  localparam int unsigned TIMEOUT = 64;

  typedef struct packed {
    logic [W-1:0] pll;
    logic [W-1:0] act;
    logic         en;
    logic         arst;
    logic         busy;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         arst_i;
  logic [W-1:0] fb_div_req_i;
  logic         clk_en_req_i, arst_req_i, glob_arst_i, err_clr_i, pll_locked_i;
  logic [W-1:0] pll_fb_div_o, fb_div_actual_o;
  logic         core_clk_en_o, core_arst_o, busy_o, lock_err_o;

  core_clk_sequencer #(
    .FB_DIV_WIDTH(W), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .arst_i(arst_i), .fb_div_req_i(fb_div_req_i),
    .clk_en_req_i(clk_en_req_i), .arst_req_i(arst_req_i), .glob_arst_i(glob_arst_i),
    .err_clr_i(err_clr_i), .pll_locked_i(pll_locked_i),
    .pll_fb_div_o(pll_fb_div_o), .fb_div_actual_o(fb_div_actual_o),
    .core_clk_en_o(core_clk_en_o), .core_arst_o(core_arst_o),
    .busy_o(busy_o), .lock_err_o(lock_err_o)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  // Reference model: a sequence is tracked by its age in edges since the mismatch was seen,
  // plus the history of lock samples taken after the retune edge.
  bit           m_active;
  int           m_age;
  bit           m_hist[$];
  logic [W-1:0] m_pll, m_act;
  logic         m_en, m_arst, m_busy, m_err;
  int           dead;
  logic [W-1:0] div_vals[6];

  function automatic exp_t cur_exp();
    exp_t e;
    e.pll = m_pll; e.act = m_act; e.en = m_en; e.arst = m_arst; e.busy = m_busy; e.err = m_err;
    return e;
  endfunction

  function automatic bit settled();
    int n = m_hist.size();
    if (n < int'(SETTLE)) return 1'b0;
    for (int i = n - int'(SETTLE); i < n; i++)
      if (!m_hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_age = 0; m_hist.delete();
    m_pll = '0; m_act = '0; m_en = 1'b0; m_arst = 1'b1; m_busy = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit set_err = 1'b0;
    m_arst = arst_req_i | glob_arst_i;
    if (!m_active) begin
      if (fb_div_req_i != m_pll) begin
        m_active = 1'b1; m_age = 0; m_en = 1'b0;
      end else begin
        m_en = clk_en_req_i & pll_locked_i;
      end
    end else begin
      m_age++;
      m_en = 1'b0;
      if (m_age == int'(GATE) + 1) begin
        m_pll = fb_div_req_i;
        m_hist.delete();
      end else if (m_age > int'(GATE) + 1) begin
        m_hist.push_back(pll_locked_i);
        if (settled()) begin
          m_act = m_pll; m_active = 1'b0;
        end else if (m_age - (int'(GATE) + 1) == int'(TIMEOUT)) begin
          set_err = 1'b1; m_active = 1'b0;
        end
      end
    end
    m_busy = m_active;
    if (set_err) m_err = 1'b1;
    else if (err_clr_i) m_err = 1'b0;
  endtask

  // One clock edge: update the model from the inputs the DUT sampled, queue the expectation
  task automatic do_cycle();
    @(posedge clk);
    if (arst_i) model_reset();
    else model_step();
    q.push_back(cur_exp());
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) do_cycle();
  endtask

  task automatic async_reset(input int n);
    arst_i = 1'b1;
    model_reset();
    q[q.size()-1] = cur_exp();
    hold(n);
    arst_i = 1'b0;
  endtask

  task automatic drive_random();
    if ($urandom_range(0, 59) == 0) fb_div_req_i = div_vals[$urandom_range(0, 5)];
    clk_en_req_i = ($urandom_range(0, 19) != 0);
    arst_req_i   = ($urandom_range(0, 49) == 0);
    glob_arst_i  = ($urandom_range(0, 79) == 0);
    err_clr_i    = ($urandom_range(0, 29) == 0);
    if (dead > 0) begin
      dead--;
      pll_locked_i = 1'b0;
    end else begin
      if ($urandom_range(0, 149) == 0) dead = 80;
      pll_locked_i = ($urandom_range(0, 14) != 0);
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every output sample is checked against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pll_fb_div", pll_fb_div_o, e.pll);
        chk("fb_div_actual", fb_div_actual_o, e.act);
        chk("core_clk_en", W'(core_clk_en_o), W'(e.en));
        chk("core_arst", W'(core_arst_o), W'(e.arst));
        chk("busy", W'(busy_o), W'(e.busy));
        chk("lock_err", W'(lock_err_o), W'(e.err));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    div_vals[0] = 12'h000; div_vals[1] = 12'h020; div_vals[2] = 12'h030;
    div_vals[3] = 12'h040; div_vals[4] = 12'hFFF; div_vals[5] = 12'h123;
    dead = 0;
    model_reset();
    arst_i = 1'b1; fb_div_req_i = '0; clk_en_req_i = 1'b1; arst_req_i = 1'b0;
    glob_arst_i = 1'b0; err_clr_i = 1'b0; pll_locked_i = 1'b1;

    // Reset release with a matching divider: no sequence, clock enabled
    hold(3);
    arst_i = 1'b0;
    hold(5);
    arst_req_i = 1'b1; hold(2); arst_req_i = 1'b0; hold(2);

    // Retune to 0x020 with a lock dropout just after the retune
    fb_div_req_i = 12'h020; hold(6);
    pll_locked_i = 1'b0; hold(3);
    pll_locked_i = 1'b1; hold(14);

    // Retune to 0x030 that never locks, then clear the error
    fb_div_req_i = 12'h030; pll_locked_i = 1'b0; hold(80);
    err_clr_i = 1'b1; hold(1); err_clr_i = 1'b0;
    pll_locked_i = 1'b1; hold(4);

    // Request change while a sequence is in LOCK_WAIT
    fb_div_req_i = 12'h020; hold(8);
    fb_div_req_i = 12'h040; hold(30);

    // Force an error, then reset asynchronously during GATE
    fb_div_req_i = 12'h050; pll_locked_i = 1'b0; hold(75);
    pll_locked_i = 1'b1; fb_div_req_i = 12'h060; hold(2);
    async_reset(3);
    hold(20);

    // Single-cycle lock drop in IDLE, then a global reset request
    pll_locked_i = 1'b0; hold(1); pll_locked_i = 1'b1; hold(3);
    glob_arst_i = 1'b1; hold(2); glob_arst_i = 1'b0; hold(2);

    // Divider of zero is a legal target
    fb_div_req_i = 12'h000; hold(20);

    repeat (3000) begin
      do_cycle();
      if ($urandom_range(0, 399) == 0) async_reset(int'($urandom_range(1, 3)));
      else drive_random();
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
